// File: rtl/indicador_pulso.sv
// Turns one-cycle event pulses into evenly spaced blinks on an active-low indicator pin.
// Optional macro INDICADOR_OVERFLOW_EN adds a sticky "overflow" output for dropped pulses.
//
// state | meaning
// IDLE  | dark, nothing in progress; starts a blink as soon as an event is pending
// ON    | indicator lit, timer counting the lit phase down
// OFF   | indicator dark, timer enforcing the minimum gap before the next blink

module indicador_pulso #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 25000000,
    parameter int TIMER_W    = 25,
    parameter int PEND_W     = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              pulso,
    input  logic              limpar,
    output logic              saida,
    output logic              ocupado,
    output logic [PEND_W-1:0] pendentes
`ifdef INDICADOR_OVERFLOW_EN
    ,
    output logic              overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } estado_t;

    localparam logic [TIMER_W-1:0] ON_CARGA  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_CARGA = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  MAX_PEND  = {PEND_W{1'b1}};

    estado_t            estado, estado_prox;
    logic [TIMER_W-1:0] timer, timer_prox;
    logic [PEND_W-1:0]  pend_prox;
    logic               inicia;
    logic               tem_pend;
    logic               timer_zero;

    assign tem_pend   = (pendentes != '0);
    assign timer_zero = (timer == '0);
    assign ocupado    = (estado != IDLE) || tem_pend;

    always_comb begin
        estado_prox = estado;
        timer_prox  = timer;
        inicia      = 1'b0;
        case (estado)
            IDLE: begin
                if (tem_pend) begin
                    estado_prox = ON;
                    timer_prox  = ON_CARGA;
                    inicia      = 1'b1;
                end
            end
            ON: begin
                if (timer_zero) begin
                    estado_prox = OFF;
                    timer_prox  = OFF_CARGA;
                end else begin
                    timer_prox = timer - 1'b1;
                end
            end
            OFF: begin
                if (timer_zero) begin
                    // back-to-back blinks skip IDLE so the gap stays exactly OFF_CYCLES
                    if (tem_pend) begin
                        estado_prox = ON;
                        timer_prox  = ON_CARGA;
                        inicia      = 1'b1;
                    end else begin
                        estado_prox = IDLE;
                        timer_prox  = '0;
                    end
                end else begin
                    timer_prox = timer - 1'b1;
                end
            end
            default: begin
                estado_prox = IDLE;
                timer_prox  = '0;
            end
        endcase
    end

    // a start and a new pulse in the same cycle cancel, even when full
    always_comb begin
        pend_prox = pendentes;
        if (pulso && !inicia) begin
            if (pendentes != MAX_PEND) begin
                pend_prox = pendentes + 1'b1;
            end
        end else if (!pulso && inicia) begin
            pend_prox = pendentes - 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET || limpar) begin
            estado    <= IDLE;
            timer     <= '0;
            pendentes <= '0;
            saida     <= 1'b1;
        end else begin
            estado    <= estado_prox;
            timer     <= timer_prox;
            pendentes <= pend_prox;
            saida     <= (estado_prox != ON);
        end
    end

`ifdef INDICADOR_OVERFLOW_EN
    logic descarta;

    assign descarta = pulso && !inicia && (pendentes == MAX_PEND);

    always_ff @(posedge CLOCK) begin
        if (RESET || limpar) begin
            overflow <= 1'b0;
        end else if (descarta) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_indicador_pulso.sv
// Self-checking bench for indicador_pulso: directed scenarios plus randomized traffic
// compared every cycle against a blink-phase reference model.

module tb_indicador_pulso;

    localparam int ON_C   = 3;
    localparam int OFF_C  = 2;
    localparam int PW     = 2;
    localparam int MAXP   = (1 << PW) - 1;
    localparam int PERIOD = ON_C + OFF_C;

    logic          CLOCK;
    logic          RESET;
    logic          pulso;
    logic          limpar;
    logic          saida;
    logic          ocupado;
    logic [PW-1:0] pendentes;
`ifdef INDICADOR_OVERFLOW_EN
    logic          overflow;
`endif

    indicador_pulso #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .TIMER_W   (4),
        .PEND_W    (PW)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .pulso    (pulso),
        .limpar   (limpar),
        .saida    (saida),
        .ocupado  (ocupado),
        .pendentes(pendentes)
`ifdef INDICADOR_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int testes = 0;
    int falhas = 0;

    // model: queued events, position inside the current blink (-1 = none), sticky drop flag
    int m_pend = 0;
    int m_fase = -1;
    int m_ovf  = 0;

    int   piscadas   = 0;
    logic saida_ant  = 1'b1;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        testes++;
        if (obs !== esp) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo(input logic p, input logic l, input logic r);
        bit comeca;
        if (r || l) begin
            m_pend = 0;
            m_fase = -1;
            m_ovf  = 0;
        end else begin
            comeca = (m_pend > 0) && (m_fase == -1 || m_fase == PERIOD - 1);
            if (comeca)                   m_fase = 0;
            else if (m_fase == PERIOD - 1) m_fase = -1;
            else if (m_fase != -1)         m_fase = m_fase + 1;
            if (p && !comeca) begin
                if (m_pend == MAXP) m_ovf = 1;
                else                m_pend = m_pend + 1;
            end else if (!p && comeca) begin
                m_pend = m_pend - 1;
            end
        end
    endtask

    task automatic confere();
        bit lit;
        lit = (m_fase >= 0) && (m_fase < ON_C);
        verifica("saida", 32'(saida), lit ? 32'd0 : 32'd1);
        verifica("pendentes", 32'(pendentes), 32'(m_pend));
        verifica("ocupado", 32'(ocupado), (m_fase != -1 || m_pend != 0) ? 32'd1 : 32'd0);
`ifdef INDICADOR_OVERFLOW_EN
        verifica("overflow", 32'(overflow), 32'(m_ovf));
`endif
    endtask

    task automatic passo(input logic p, input logic l, input logic r);
        pulso  = p;
        limpar = l;
        RESET  = r;
        @(posedge CLOCK);
        modelo(p, l, r);
        #1;
        confere();
        if (saida_ant === 1'b1 && saida === 1'b0) piscadas++;
        saida_ant = saida;
    endtask

    task automatic ocioso(input int n);
        for (int i = 0; i < n; i++) passo(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        pulso  = 1'b0;
        limpar = 1'b0;
        RESET  = 1'b1;

        // reset, then quiet
        passo(1'b0, 1'b0, 1'b1);
        passo(1'b0, 1'b0, 1'b1);
        ocioso(8);
        verifica("reset_saida", 32'(saida), 32'd1);
        verifica("reset_pend", 32'(pendentes), 32'd0);
        verifica("reset_ocup", 32'(ocupado), 32'd0);

        // single event
        piscadas = 0;
        passo(1'b1, 1'b0, 1'b0);
        verifica("s2_pend_c1", 32'(pendentes), 32'd1);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s2_saida_c2", 32'(saida), 32'd0);
        ocioso(2);
        verifica("s2_saida_c4", 32'(saida), 32'd0);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s2_saida_c5", 32'(saida), 32'd1);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s2_ocup_c6", 32'(ocupado), 32'd1);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s2_ocup_c7", 32'(ocupado), 32'd0);
        ocioso(5);
        verifica("s2_blinks", 32'(piscadas), 32'd1);

        // burst of three
        piscadas = 0;
        for (int k = 0; k < 16; k++) passo(k < 3, 1'b0, 1'b0);
        verifica("s3_ocup_c16", 32'(ocupado), 32'd1);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s3_ocup_c17", 32'(ocupado), 32'd0);
        ocioso(5);
        verifica("s3_blinks", 32'(piscadas), 32'd3);

        // saturation
        piscadas = 0;
        passo(1'b1, 1'b0, 1'b0);
        passo(1'b1, 1'b0, 1'b0);
        verifica("s4_pend_c2", 32'(pendentes), 32'd1);
        passo(1'b1, 1'b0, 1'b0);
        passo(1'b1, 1'b0, 1'b0);
        verifica("s4_pend_c4", 32'(pendentes), 32'd3);
        passo(1'b1, 1'b0, 1'b0);
        verifica("s4_pend_c5", 32'(pendentes), 32'd3);
`ifdef INDICADOR_OVERFLOW_EN
        verifica("s4_ovf_c5", 32'(overflow), 32'd1);
`endif
        ocioso(30);
        verifica("s4_blinks", 32'(piscadas), 32'd4);

        // clear mid-blink with a coincident pulse
        piscadas = 0;
        passo(1'b1, 1'b0, 1'b0);
        passo(1'b1, 1'b0, 1'b0);
        passo(1'b0, 1'b0, 1'b0);
        passo(1'b1, 1'b1, 1'b0);
        verifica("s5_saida_c4", 32'(saida), 32'd1);
        verifica("s5_pend_c4", 32'(pendentes), 32'd0);
        verifica("s5_ocup_c4", 32'(ocupado), 32'd0);
`ifdef INDICADOR_OVERFLOW_EN
        verifica("s5_ovf_c4", 32'(overflow), 32'd0);
`endif
        ocioso(15);
        verifica("s5_blinks", 32'(piscadas), 32'd1);

        // reset mid-blink, then a fresh event
        passo(1'b1, 1'b0, 1'b0);
        ocioso(2);
        passo(1'b0, 1'b0, 1'b1);
        verifica("s6_saida_c4", 32'(saida), 32'd1);
        verifica("s6_ocup_c4", 32'(ocupado), 32'd0);
        ocioso(2);
        passo(1'b1, 1'b0, 1'b0);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s6_saida_c8", 32'(saida), 32'd0);
        ocioso(2);
        verifica("s6_saida_c10", 32'(saida), 32'd0);
        passo(1'b0, 1'b0, 1'b0);
        verifica("s6_saida_c11", 32'(saida), 32'd1);
        ocioso(10);

        // randomized traffic with a varying event rate
        for (int blk = 0; blk < 20; blk++) begin
            int taxa;
            taxa = $urandom_range(5, 90);
            for (int i = 0; i < 150; i++) begin
                logic p, l, r;
                p = ($urandom_range(0, 99) < taxa);
                l = ($urandom_range(0, 199) < 3);
                r = ($urandom_range(0, 399) < 2);
                passo(p, l, r);
            end
        end
        ocioso(40);
        verifica("final_ocup", 32'(ocupado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/indicador_pulso.md
Name: indicador_pulso

Overview:
- Output-side counterpart of the button input path: converts one-cycle internal event pulses into human-visible blinks on an active-low LED/indicator pin.
- Queues events that arrive while a blink is in progress and replays them as separate, evenly spaced blinks.
- Sits between control logic (event pulses) and board output pins.

Parameters:
ON_CYCLES, 25000000, cycles the indicator is lit per blink (0.5 s at 50 MHz); must be >=1 and <2^TIMER_W
OFF_CYCLES, 25000000, minimum dark gap after each blink; must be >=1 and <2^TIMER_W
TIMER_W, 25, width of the internal phase timer
PEND_W, 4, width of the pending-event counter; capacity MAX_PEND = 2^PEND_W-1

Ports:
CLOCK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
pulso  input  1  event pulse, one blink requested per cycle high
limpar  input  1  synchronous clear of queue and current blink
saida  output  1  indicator drive, active-low (0 = lit)
ocupado  output  1  high while blinking or events pending
pendentes  output  PEND_W  events queued and not yet started

Behaviour:
- All outputs registered except ocupado (combinational from registers). Reset values: saida=1, pendentes=0, ocupado=0, state IDLE, timer=0.
- Priority per edge: RESET > limpar > normal operation.
- Pending counter: +1 when pulso=1; -1 when a blink starts. Increment and decrement in the same cycle leave it unchanged. This includes the case pendentes=MAX_PEND, so nothing is lost.
- Saturation: if pulso=1, pendentes=MAX_PEND and no decrement in that cycle, the pulse is dropped and the counter stays at MAX_PEND.
- FSM states: IDLE, ON, OFF.
  - IDLE: saida=1. If pendentes!=0, next state is ON, pendentes is decremented, timer loads ON_CYCLES-1.
  - ON: saida=0. Timer decrements each cycle. At timer==0, next state is OFF and timer loads OFF_CYCLES-1.
  - OFF: saida=1. Timer decrements. At timer==0: if pendentes!=0, go directly to ON (decrement, load ON_CYCLES-1); otherwise go to IDLE.
- Timing: saida is low for exactly ON_CYCLES cycles per blink. The gap between blinks is exactly OFF_CYCLES cycles.
- Latency: pulso high in cycle 0 gives pendentes=1 in cycle 1 and saida=0 in cycle 2.
- ocupado = (state!=IDLE) OR (pendentes!=0).
- limpar=1:
  - Next cycle: state IDLE, saida=1, pendentes=0, timer=0.
  - A pulso in the same cycle is discarded.
  - A blink in progress is cut short with no OFF gap enforced.
- RESET mid-blink: same effect as limpar, and also clears all feature state.
- pulso held high for N cycles counts as N events; no edge detection in this block.

Optional Feature:
- Macro: INDICADOR_OVERFLOW_EN.
- Defined: adds port "overflow  output  1". This is a sticky flag set on the edge where a pulse is dropped by saturation. Cleared only by RESET or limpar; if limpar and a dropping pulse coincide, limpar wins (flag=0). Reset value 0.
- Undefined: port and logic absent; saturated pulses are dropped silently. All other behaviour is identical.

Test Plan:
All scenarios use ON_CYCLES=3, OFF_CYCLES=2, PEND_W=2 (MAX_PEND=3).
1. Reset: RESET high 2 cycles, then low with pulso=0 -> saida=1, pendentes=0, ocupado=0 held indefinitely.
2. Single event: pulso high in cycle 0 only -> pendentes=1 in cycle 1; saida=0 cycles 2-4; saida=1 cycles 5-6; IDLE and ocupado=0 from cycle 7.
3. Burst of 3: pulso high in cycles 0-2 -> three blinks with saida=0 in cycles 2-4, 7-9, 12-14; ocupado=0 from cycle 17.
4. Saturation: pulso high in cycles 0-4:
   - Cycle 1 start-plus-increment keeps pendentes=1.
   - pendentes reaches 3 at cycle 4 and stays 3 at cycle 5 (pulse in cycle 4 dropped).
   - Exactly 4 blinks total; overflow=1 from cycle 5 when INDICADOR_OVERFLOW_EN is defined.
5. Clear mid-blink: 2 events queued, limpar high in cycle 3 together with pulso -> cycle 4: saida=1, pendentes=0, ocupado=0, overflow=0; no further blinks.
6. Reset mid-blink: RESET high in cycle 3 of scenario 2 -> cycle 4 shows reset values; a new pulso in cycle 6 blinks normally (saida=0 cycles 8-10).
